// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one synchronous memory.
// Data has priority; a fetch starved for STARVE_MAX arbitrations wins the next one.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wren,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        owner;        // 1 = data port owns the access in flight
  logic [3:0]  starve_cnt;

  logic        arb;
  logic        f_win;
  logic        d_win;
  logic        resp_v;
  logic [31:0] rd;

  always_comb begin
    arb   = !reset && (state == IDLE || state == RESP);
    f_win = arb && f_req && (!d_req || (starve_cnt >= 4'(STARVE_MAX)));
    d_win = arb && d_req && !f_win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      owner      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (f_win) begin
            state      <= ACCESS;
            owner      <= 1'b0;
            addr_q     <= f_addr;
            we_q       <= 1'b0;
            funct3_q   <= 3'b010;
            wdata_q    <= '0;
            starve_cnt <= '0;
          end else if (d_win) begin
            state    <= ACCESS;
            owner    <= 1'b1;
            addr_q   <= d_addr;
            we_q     <= d_we;
            funct3_q <= d_funct3;
            wdata_q  <= d_wdata;
            if (f_req && starve_cnt != 4'd15)
              starve_cnt <= starve_cnt + 4'd1;
            else if (!f_req)
              starve_cnt <= '0;
          end else begin
            state      <= IDLE;
            starve_cnt <= '0;
          end
        end
        ACCESS:  state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // Response is suppressed in a reset cycle so an aborted access never completes.
  always_comb begin
    resp_v   = (state == RESP) && !reset;
    rd       = we_q ? '0 : mem_rdata;
    f_gnt    = f_win;
    d_gnt    = d_win;
    f_rvalid = resp_v && !owner;
    d_rvalid = resp_v && owner;
    f_rdata  = f_rvalid ? rd : '0;
    d_rdata  = d_rvalid ? rd : '0;
    mem_wren = (state == ACCESS) && we_q;
    busy     = (state != IDLE);
  end

  assign mem_addr   = addr_q;
  assign mem_funct3 = funct3_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a grant-timestamp reference model.
module tb_mem_arbiter;

  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wren, busy;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_funct3(mem_funct3),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Synchronous memory: data for an address appears one cycle later.
  always @(posedge clk) mem_rdata <= mem_word(mem_addr);

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one transaction in flight, located in time by its grant cycle.
  int          cyc = 0;
  int          g = -100;
  int          starve = 0;
  logic        t_data = 1'b0, t_we = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  logic [2:0]  t_f3 = '0;
  bit          m_fg = 1'b0, m_dg = 1'b0;
  bit          rec = 1'b0;
  bit          order[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit acc, rsp, fw, dw;
    logic [31:0] rd;
    @(negedge clk);
    acc = (cyc == g + 1);
    rsp = (cyc == g + 2);
    fw = 1'b0;
    dw = 1'b0;
    if (!reset && !acc) begin
      if (f_req && (!d_req || starve >= int'(SM))) fw = 1'b1;
      else if (d_req) dw = 1'b1;
    end
    rd = (rsp && !reset) ? (t_we ? 32'h0 : mem_word(t_addr)) : 32'h0;
    chk("f_gnt", 32'(f_gnt), 32'(fw));
    chk("d_gnt", 32'(d_gnt), 32'(dw));
    chk("both_gnt", 32'(f_gnt & d_gnt), 32'h0);
    chk("busy", 32'(busy), 32'(acc || rsp));
    chk("mem_wren", 32'(mem_wren), 32'(acc && t_we));
    chk("f_rvalid", 32'(f_rvalid), 32'(rsp && !reset && !t_data));
    chk("d_rvalid", 32'(d_rvalid), 32'(rsp && !reset && t_data));
    chk("f_rdata", f_rdata, t_data ? 32'h0 : rd);
    chk("d_rdata", d_rdata, t_data ? rd : 32'h0);
    chk("mem_addr", mem_addr, t_addr);
    chk("mem_funct3", 32'(mem_funct3), 32'(t_f3));
    chk("mem_wdata", mem_wdata, t_wdata);
    if (rec && (f_gnt || d_gnt)) order.push_back(d_gnt);
    if (reset) begin
      t_data = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_f3 = '0;
      g = -100; starve = 0;
    end else if (fw) begin
      t_data = 0; t_we = 0; t_addr = f_addr; t_wdata = '0; t_f3 = 3'b010;
      g = cyc; starve = 0;
    end else if (dw) begin
      t_data = 1; t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_f3 = d_funct3;
      g = cyc;
      starve = f_req ? ((starve < 15) ? starve + 1 : 15) : 0;
    end else if (!acc) begin
      starve = 0;
    end
    m_fg = fw;
    m_dg = dw;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    f_req = 0; f_addr = '0;
    d_req = 0; d_we = 0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;

    // single fetch
    f_req = 1; f_addr = 32'h0000_1000;
    step();
    f_req = 0;
    repeat (3) step();

    // single store
    d_req = 1; d_we = 1; d_addr = 32'h0000_2004; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b000;
    step();
    d_req = 0; d_we = 0;
    repeat (3) step();

    // continuous contention
    rec = 1;
    f_req = 1; f_addr = 32'h0000_3000;
    d_req = 1; d_addr = 32'h0000_4000; d_wdata = 32'h1111_2222; d_funct3 = 3'b010;
    repeat (20) step();
    rec = 0;
    f_req = 0; d_req = 0;
    repeat (2) step();
    chk("grant_count", 32'(order.size()), 32'd10);
    for (int i = 0; i < order.size(); i++)
      chk("grant_order", 32'(order[i]), 32'((i % 5) != 4));

    // reset during a read's memory cycle, fetch held through reset
    f_req = 1; f_addr = 32'h0000_5000;
    step();
    reset = 1;
    step();
    reset = 0;
    step();
    f_req = 0;
    repeat (3) step();

    // reset during a write's memory cycle
    d_req = 1; d_we = 1; d_addr = 32'h0000_6000; d_wdata = 32'hCAFE_F00D; d_funct3 = 3'b001;
    step();
    d_req = 0;
    reset = 1;
    step();
    reset = 0; d_we = 0;
    repeat (2) step();

    // back-to-back: data released during ACCESS, fetch pending
    d_req = 1; d_we = 0; d_addr = 32'h0000_7000; d_funct3 = 3'b100;
    f_req = 1; f_addr = 32'h0000_8000;
    step();
    d_req = 0;
    step();
    step();
    f_req = 0;
    repeat (3) step();

    // randomized traffic with occasional reset
    repeat (400) begin
      if (m_fg || !f_req) begin
        f_req  = ($urandom_range(0, 2) == 0);
        f_addr = $urandom;
      end
      if (m_dg || !d_req) begin
        d_req    = 1'($urandom_range(0, 1));
        d_we     = 1'($urandom_range(0, 1));
        d_funct3 = 3'($urandom_range(0, 7));
        d_addr   = $urandom;
        d_wdata  = $urandom;
      end
      reset = ($urandom_range(0, 50) == 0);
      step();
    end
    reset = 0; f_req = 0; d_req = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
